mux_32to1_reg: RTL and testbench

- Registered 32-to-1 single-bit multiplexer: selects bit `data_i[sel_i]` and presents it on `out_o` one clock after capture.
- Sits in datapath bit-select / test-mux paths where a timing-clean registered select result is needed.
- Carries a valid qualifier alongside the data.
- Core select logic is a pure combinational tree; the wrapper adds the pipeline register and reset.

---
 rtl/mux_32to1_pkg.sv | 18 +
 rtl/mux_32to1_reg_if.sv | 50 +++++
 rtl/mux_32to1_comb.sv | 40 ++++
 rtl/mux_32to1_reg.sv | 61 ++++++
 tb/tb_mux_32to1_reg.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/mux_32to1_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mux_32to1_pkg                                                 |
// | Description : Shared sizes and types for the registered 32:1 bit mux.      |
// |               N_IN  - number of data lanes (32 is the only supported size) |
// |               SEL_W - select width, derived from N_IN                      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package mux_32to1_pkg;

  localparam int N_IN  = 32;
  localparam int SEL_W = $clog2(N_IN);

  typedef logic [N_IN-1:0]  mux_data_t;
  typedef logic [SEL_W-1:0] mux_sel_t;

endpackage : mux_32to1_pkg
`default_nettype wire

// File: rtl/mux_32to1_reg_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mux_32to1_reg_if                                              |
// | Description : Bus bundle between a mux user (master) and the registered    |
// |               32:1 mux (slave).                                            |
// |               data_i  - 32 data lanes, bit k is input k                    |
// |               sel_i   - binary lane select                                 |
// |               valid_i - qualifies data_i/sel_i for capture                 |
// |               out_o   - registered selected bit                            |
// |               valid_o - high when out_o holds a fresh result               |
// |               out_comb_o - combinational selected bit, present only when   |
// |                            MUX_32TO1_COMB_OUT_EN is defined                |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface mux_32to1_reg_if;
  import mux_32to1_pkg::*;

  mux_data_t data_i;
  mux_sel_t  sel_i;
  logic      valid_i;
  logic      out_o;
  logic      valid_o;
`ifdef MUX_32TO1_COMB_OUT_EN
  logic      out_comb_o;
`endif

  modport master (
    output data_i,
    output sel_i,
    output valid_i,
`ifdef MUX_32TO1_COMB_OUT_EN
    input  out_comb_o,
`endif
    input  out_o,
    input  valid_o
  );

  modport slave (
    input  data_i,
    input  sel_i,
    input  valid_i,
`ifdef MUX_32TO1_COMB_OUT_EN
    output out_comb_o,
`endif
    output out_o,
    output valid_o
  );

endinterface : mux_32to1_reg_if
`default_nettype wire

// File: rtl/mux_32to1_comb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mux_32to1_comb                                                |
// | Description : Purely combinational 32:1 single-bit mux built as a tree of  |
// |               2:1 stages, one level per select bit, LSB first.             |
// |               data_i - data lanes                                          |
// |               sel_i  - binary lane select                                  |
// |               out_o  - data_i[sel_i]                                       |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module mux_32to1_comb
  import mux_32to1_pkg::*;
(
  input  mux_data_t data_i,
  input  mux_sel_t  sel_i,
  output logic      out_o
);

  // All tree levels packed into one vector: level l starts at offset
  // 2*N_IN - (2*N_IN >> l) and holds N_IN >> l nodes; the root is the top bit.
  logic [2*N_IN-2:0] w_node;

  assign w_node[N_IN-1:0] = data_i;

  genvar l, j;
  generate
    for (l = 0; l < SEL_W; l++) begin : g_level
      localparam int C_IN_BASE  = 2*N_IN - ((2*N_IN) >> l);
      localparam int C_OUT_BASE = 2*N_IN - ((2*N_IN) >> (l+1));
      for (j = 0; j < (N_IN >> (l+1)); j++) begin : g_node
        assign w_node[C_OUT_BASE+j] = sel_i[l] ? w_node[C_IN_BASE+2*j+1]
                                               : w_node[C_IN_BASE+2*j];
      end
    end
  endgenerate

  assign out_o = w_node[2*N_IN-2];

endmodule : mux_32to1_comb
`default_nettype wire

// File: rtl/mux_32to1_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mux_32to1_reg                                                 |
// | Description : Registered 32:1 single-bit mux with valid qualifier.         |
// |               A captured sample appears on out_o/valid_o one clock later;  |
// |               without valid_i, out_o holds and valid_o drops.              |
// |               clk_i - clock, rising edge                                   |
// |               rst_i - synchronous active-high reset                        |
// |               bus   - mux_32to1_reg_if slave modport                       |
// |               Optional: MUX_32TO1_COMB_OUT_EN adds bus.out_comb_o, the     |
// |               unregistered select result.                                  |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module mux_32to1_reg
  import mux_32to1_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
)(
  input  logic             clk_i,
  input  logic             rst_i,
  mux_32to1_reg_if.slave   bus
);

  logic w_sel_bit;
  logic out_d,   out_q;
  logic valid_d, valid_q;

  mux_32to1_comb u_comb (
    .data_i (bus.data_i),
    .sel_i  (bus.sel_i),
    .out_o  (w_sel_bit)
  );

  always_comb begin
    out_d   = out_q;
    valid_d = 1'b0;
    if (bus.valid_i) begin
      out_d   = w_sel_bit;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q   <= RST_VAL;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign bus.out_o   = out_q;
  assign bus.valid_o = valid_q;

`ifdef MUX_32TO1_COMB_OUT_EN
  assign bus.out_comb_o = w_sel_bit;
`endif

endmodule : mux_32to1_reg
`default_nettype wire

// File: tb/tb_mux_32to1_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mux_32to1_reg                                              |
// | Description : Scoreboard bench for mux_32to1_reg. Stimulus pushes the      |
// |               hand-computed expected bit; a monitor pops and compares on   |
// |               every valid_o. Honours MUX_32TO1_COMB_OUT_EN.                |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mux_32to1_reg;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic exp_q[$];

  mux_32to1_reg_if bus ();

  mux_32to1_reg #(.RST_VAL(1'b0)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Present one valid vector for one cycle; expected result goes to the queue.
  task automatic send(input logic [31:0] d, input logic [4:0] s, input logic e);
    bus.data_i  = d;
    bus.sel_i   = s;
    bus.valid_i = 1'b1;
    exp_q.push_back(e);
`ifdef MUX_32TO1_COMB_OUT_EN
    #1;
    chk("out_comb_o", bus.out_comb_o, e);
`endif
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid_o must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got valid_o=1 expected no output at %0t", $time);
        end else begin
          chk("out_o", bus.out_o, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst         = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i  = 32'hFFFF_FFFF;
    bus.sel_i   = 5'd0;

    // Reset overrides valid_i for two cycles
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("rst_out_o", bus.out_o, 1'b0);
      chk("rst_valid_o", bus.valid_o, 1'b0);
    end
    bus.valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_valid_o", bus.valid_o, 1'b0);
    chk("idle_out_o", bus.out_o, 1'b0);

    // LSB select
    send(32'h4F2B3666, 5'd0, 1'b0);
    send(32'b1001111001010110011011001101011, 5'd0, 1'b1);
    // Mid select
    send(32'b10101001100110011001100111001100, 5'd20, 1'b1);
    send(32'b10101001100110011001100111001100, 5'd0, 1'b0);
    // All ones / high select
    send(32'hFFFF_FFFF, 5'd28, 1'b1);
    send(32'h0000_0000, 5'd31, 1'b0);
    // Low select
    send(32'b01000000111000000000001100001101, 5'd3, 1'b1);
    send(32'b01000000111000000000001100001101, 5'd1, 1'b0);
    // Walking one, back to back
    for (int k = 0; k < 32; k++) begin
      logic [31:0] d;
      d = 32'd1 << k;
      send(d, 5'(k), 1'b1);
    end
    // Drop valid: output holds, valid falls
    bus.valid_i = 1'b0;
    bus.data_i  = 32'h0;
    bus.sel_i   = 5'd0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("hold_out_o", bus.out_o, 1'b1);
      chk("hold_valid_o", bus.valid_o, 1'b0);
    end

    // Mid-stream reset discards the in-flight sample
    bus.valid_i = 1'b1;
    bus.data_i  = 32'hFFFF_FFFF;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.valid_i = 1'b0;
    chk("midrst_out_o", bus.out_o, 1'b0);
    chk("midrst_valid_o", bus.valid_o, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL outstanding: got %0d pending results expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mux_32to1_reg
`default_nettype wire
